// File: rtl/tdes_job_arbiter.sv
// tdes_job_arbiter: shares one triple-DES core among NREQ requesters.
// A round-robin arbiter picks one job, holds its operands on the core inputs,
// pulses core_enable, waits for core_done under a watchdog, and returns the
// result to the owning requester over a valid/ready handshake.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   req_valid/req_ready   per-requester job handshake (req_ready one-hot)
//   req_encr, req_data,
//   req_key1..3           per-requester operands, requester i at [64*i+63:64*i]
//   rsp_valid/rsp_ready   per-requester result handshake (rsp_valid one-hot)
//   rsp_data, rsp_error   shared result bus; rsp_error = watchdog abort
//   core_enable           one-cycle start pulse to the core
//   core_encr, core_data,
//   core_key1..3          operand registers to the core
//   core_result, core_done core output and completion strobe
//   busy                  FSM not idle
//   grant_id              current/last granted requester
module tdes_job_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_encr,
    input  logic [NREQ*64-1:0]   req_data,
    input  logic [NREQ*64-1:0]   req_key1,
    input  logic [NREQ*64-1:0]   req_key2,
    input  logic [NREQ*64-1:0]   req_key3,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_error,
    output logic                 core_enable,
    output logic                 core_encr,
    output logic [63:0]          core_data,
    output logic [63:0]          core_key1,
    output logic [63:0]          core_key2,
    output logic [63:0]          core_key3,
    input  logic [63:0]          core_result,
    input  logic                 core_done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [CNTW-1:0] cnt_q;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            timeout_hit;
    int unsigned     scan_idx;

    // Watchdog expires on the TIMEOUT-th WAIT cycle (counter starts at 0).
    assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

    // Round-robin search: first valid requester upward from ptr+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            scan_idx = (32'(ptr_q) + 32'd1 + 32'(k)) % NREQ;
            if (!win_found && req_valid[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; core_done only matters in WAIT and beats the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_found) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (core_done || timeout_hit) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready[grant_id]) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake and strobe outputs.
    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        core_enable = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (win_found && !HRESET) req_ready[win_id] = 1'b1;
            end
            ST_ISSUE: core_enable = 1'b1;
            ST_RESP:  rsp_valid[grant_id] = 1'b1;
            default:  ;
        endcase
    end

    // Operand capture, watchdog, result capture and fairness pointer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ptr_q     <= IDW'(NREQ - 1);
            grant_id  <= '0;
            cnt_q     <= '0;
            core_encr <= 1'b0;
            core_data <= '0;
            core_key1 <= '0;
            core_key2 <= '0;
            core_key3 <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_id  <= win_id;
                        core_encr <= req_encr[win_id];
                        core_data <= req_data[{win_id, 6'd0} +: 64];
                        core_key1 <= req_key1[{win_id, 6'd0} +: 64];
                        core_key2 <= req_key2[{win_id, 6'd0} +: 64];
                        core_key3 <= req_key3[{win_id, 6'd0} +: 64];
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    if (core_done) begin
                        rsp_data  <= core_result;
                        rsp_error <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Just-served requester gets the lowest priority next time.
                    if (rsp_ready[grant_id]) ptr_q <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_job_arbiter.sv
// Directed testbench for tdes_job_arbiter (NREQ=2, TIMEOUT=8).
module tb_tdes_job_arbiter;

    logic         HCLK;
    logic         HRESET;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_encr;
    logic [127:0] req_data;
    logic [127:0] req_key1;
    logic [127:0] req_key2;
    logic [127:0] req_key3;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [63:0]  rsp_data;
    logic         rsp_error;
    logic         core_enable;
    logic         core_encr;
    logic [63:0]  core_data;
    logic [63:0]  core_key1;
    logic [63:0]  core_key2;
    logic [63:0]  core_key3;
    logic [63:0]  core_result;
    logic         core_done;
    logic         busy;
    logic [0:0]   grant_id;

    int total = 0;
    int bad   = 0;

    tdes_job_arbiter #(.NREQ(2), .TIMEOUT(8)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_encr    (req_encr),
        .req_data    (req_data),
        .req_key1    (req_key1),
        .req_key2    (req_key2),
        .req_key3    (req_key3),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .core_enable (core_enable),
        .core_encr   (core_encr),
        .core_data   (core_data),
        .core_key1   (core_key1),
        .core_key2   (core_key2),
        .core_key3   (core_key3),
        .core_result (core_result),
        .core_done   (core_done),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step;
        @(negedge HCLK);
    endtask

    // Runs one job for requester id whose done arrives lat cycles after
    // core_enable. Starts at an IDLE negedge with req_valid already driven.
    // With hold=1 it returns at the first RESP negedge, otherwise one cycle later.
    task automatic run_job(input int id, input int lat, input logic [63:0] res, input bit hold);
        logic [1:0] oh;
        oh = 2'b01 << id;
        #1;
        total++;
        if (req_ready !== oh) begin
            bad++;
            $display("FAIL job_accept id=%0d: req_ready=%b want %b", id, req_ready, oh);
        end
        step;
        total++;
        if (core_enable !== 1'b1 || grant_id !== 1'(id) || busy !== 1'b1 ||
            core_encr !== req_encr[id] || core_data !== req_data[id*64 +: 64] ||
            core_key1 !== req_key1[id*64 +: 64] || core_key2 !== req_key2[id*64 +: 64] ||
            core_key3 !== req_key3[id*64 +: 64]) begin
            bad++;
            $display("FAIL job_issue id=%0d: en=%b gid=%0d encr=%b data=%h k1=%h want data=%h",
                     id, core_enable, grant_id, core_encr, core_data, core_key1, req_data[id*64 +: 64]);
        end
        for (int i = 1; i <= lat; i++) begin
            step;
            if (i == lat) begin
                core_done   = 1'b1;
                core_result = res;
            end
            #1;
            total++;
            if (core_enable !== 1'b0 || rsp_valid !== 2'b00 || grant_id !== 1'(id) ||
                core_data !== req_data[id*64 +: 64]) begin
                bad++;
                $display("FAIL job_wait id=%0d cyc=%0d: en=%b rsp_valid=%b gid=%0d data=%h",
                         id, i, core_enable, rsp_valid, grant_id, core_data);
            end
        end
        step;
        core_done   = 1'b0;
        core_result = 64'h0;
        #1;
        total++;
        if (rsp_valid !== oh || rsp_data !== res || rsp_error !== 1'b0) begin
            bad++;
            $display("FAIL job_resp id=%0d: rsp_valid=%b data=%h err=%b want %b %h 0",
                     id, rsp_valid, rsp_data, rsp_error, oh, res);
        end
        if (!hold) step;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        step;
        step;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || core_enable !== 1'b0 ||
            grant_id !== 1'b0 || core_data !== 64'h0 || core_key1 !== 64'h0 ||
            core_encr !== 1'b0 || rsp_data !== 64'h0 || rsp_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b rsp_valid=%b en=%b gid=%0d data=%h rsp=%h err=%b",
                     busy, rsp_valid, core_enable, grant_id, core_data, rsp_data, rsp_error);
        end
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b want 00", req_ready);
        end
        req_valid = 2'b00;
        HRESET    = 1'b0;
        step;
    endtask

    task automatic test_single;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        run_job(0, 4, 64'hDEADBEEF00C0FFEE, 1'b0);
        req_valid = 2'b00;
        #1;
        total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 64'hDEADBEEF00C0FFEE) begin
            bad++;
            $display("FAIL single_after: rsp_valid=%b busy=%b data=%h", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_contention;
        HRESET = 1'b1;
        step;
        HRESET    = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        run_job(0, 1, 64'h1111000011110000, 1'b0);
        run_job(1, 2, 64'h2222000022220000, 1'b0);
        run_job(0, 3, 64'h3333000033330000, 1'b0);
        run_job(1, 1, 64'h4444000044440000, 1'b0);
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure;
        req_valid = 2'b10;
        rsp_ready = 2'b01;
        run_job(1, 2, 64'h5555AAAA5555AAAA, 1'b1);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (rsp_valid !== 2'b10 || rsp_data !== 64'h5555AAAA5555AAAA || rsp_error !== 1'b0 ||
                req_ready !== 2'b00 || core_enable !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL backpressure_hold cyc=%0d: rsp_valid=%b data=%h req_ready=%b busy=%b",
                         i, rsp_valid, rsp_data, req_ready, busy);
            end
            step;
        end
        rsp_ready = 2'b11;
        step;
        run_job(0, 1, 64'h0F0F0F0F0F0F0F0F, 1'b0);
        req_valid = 2'b00;
    endtask

    task automatic test_timeout;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        // done on the same cycle the watchdog expires: done wins
        run_job(0, 8, 64'hC0DEC0DEC0DEC0DE, 1'b0);
        rsp_ready = 2'b00;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL timeout_accept: req_ready=%b want 01", req_ready);
        end
        step;
        req_valid = 2'b00;
        total++;
        if (core_enable !== 1'b1) begin
            bad++;
            $display("FAIL timeout_issue: core_enable=%b want 1", core_enable);
        end
        for (int i = 1; i <= 8; i++) begin
            step;
            total++;
            if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
                bad++;
                $display("FAIL timeout_wait cyc=%0d: rsp_valid=%b busy=%b", i, rsp_valid, busy);
            end
        end
        step;
        total++;
        if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_data !== 64'h0) begin
            bad++;
            $display("FAIL timeout_resp: rsp_valid=%b err=%b data=%h want 01 1 0",
                     rsp_valid, rsp_error, rsp_data);
        end
        step;
        step;
        core_done   = 1'b1;
        core_result = 64'hBADBADBADBADBAD0;
        step;
        core_done   = 1'b0;
        core_result = 64'h0;
        #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_data !== 64'h0) begin
            bad++;
            $display("FAIL timeout_late_done: rsp_valid=%b err=%b data=%h", rsp_valid, rsp_error, rsp_data);
        end
        rsp_ready = 2'b11;
        step;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL timeout_release: busy=%b rsp_valid=%b", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        step;
        req_valid = 2'b00;
        step;
        step;
        HRESET = 1'b1;
        step;
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || core_enable !== 1'b0 || req_ready !== 2'b00 ||
            grant_id !== 1'b0 || core_data !== 64'h0 || core_key3 !== 64'h0 || core_encr !== 1'b0 ||
            rsp_data !== 64'h0 || rsp_error !== 1'b0) begin
            bad++;
            $display("FAIL midwait_reset: busy=%b rsp_valid=%b en=%b gid=%0d data=%h rsp=%h",
                     busy, rsp_valid, core_enable, grant_id, core_data, rsp_data);
        end
        HRESET    = 1'b0;
        core_done = 1'b1;
        core_result = 64'h7777777777777777;
        step;
        core_done = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 64'h0) begin
            bad++;
            $display("FAIL midwait_late_done: busy=%b rsp_valid=%b data=%h", busy, rsp_valid, rsp_data);
        end
        req_valid = 2'b10;
        run_job(1, 3, 64'h0123012301230123, 1'b0);
        req_valid = 2'b00;
    endtask

    task automatic test_spurious_done;
        core_done   = 1'b1;
        core_result = 64'hFFFF0000FFFF0000;
        step;
        core_done = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 64'h0123012301230123) begin
            bad++;
            $display("FAIL spurious_idle: busy=%b rsp_valid=%b data=%h", busy, rsp_valid, rsp_data);
        end
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        run_job(0, 2, 64'hABCDABCDABCDABCD, 1'b1);
        req_valid   = 2'b00;
        core_done   = 1'b1;
        core_result = 64'h9999999999999999;
        step;
        core_done = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_data !== 64'hABCDABCDABCDABCD || rsp_error !== 1'b0 ||
            busy !== 1'b1) begin
            bad++;
            $display("FAIL spurious_resp: rsp_valid=%b data=%h err=%b busy=%b",
                     rsp_valid, rsp_data, rsp_error, busy);
        end
        rsp_ready = 2'b11;
        step;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL spurious_release: busy=%b rsp_valid=%b", busy, rsp_valid);
        end
    endtask

    initial begin
        HRESET      = 1'b1;
        req_valid   = 2'b00;
        rsp_ready   = 2'b00;
        req_encr    = 2'b01;
        req_data    = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        req_key1    = {64'h1F1F1F1F0E0E0E0E, 64'h133457799BBCDFF1};
        req_key2    = {64'h2E2E2E2E3D3D3D3D, 64'hA1B2C3D4E5F60718};
        req_key3    = {64'h4C4C4C4C5B5B5B5B, 64'h0F1E2D3C4B5A6978};
        core_result = 64'h0;
        core_done   = 1'b0;

        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_timeout;
        test_reset_mid_wait;
        test_spurious_done;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
